// File: rtl/input_debounce_filter.sv
// input_debounce_filter: synchronizes a raw board input and rejects
// pulses shorter than a programmable number of timebase ticks.
module input_debounce_filter #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic        RST_VALUE    = 1'b1,
    parameter int unsigned GLITCH_CNT_W = 8
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic                    iTick,
    input  logic                    iEnable,
    input  logic [15:0]             iDebounce_time,
    input  logic                    iClear_glitch,
    input  logic                    input_sig,
    output logic                    output_sig,
    output logic                    output_busy,
    output logic [GLITCH_CNT_W-1:0] output_glitch_cnt
);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0]  r_sync;
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [15:0]             r_cnt;
    logic [15:0]             w_cnt_nxt;
    logic                    r_out;
    logic                    w_out_nxt;
    logic                    w_glitch;
    logic [GLITCH_CNT_W-1:0] r_glitch_cnt;
    logic                    w_s_sync;
    logic                    w_bypass;
    logic [16:0]             w_cnt_inc;
    logic                    w_thresh;

    assign w_s_sync  = r_sync[SYNC_STAGES-1];
    assign w_bypass  = !iEnable || (iDebounce_time == 16'd0);
    assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
    assign w_thresh  = w_cnt_inc >= {1'b0, iDebounce_time};

    // Metastability chain; only the last stage feeds the filter.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_sync <= {SYNC_STAGES{RST_VALUE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], input_sig};
        end
    end

    // State, tick counter and debounced level registers.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= ST_STABLE;
            r_cnt   <= 16'd0;
            r_out   <= RST_VALUE;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
        end
    end

    // Next-state: bypass overrides, a return to the old level beats a tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_glitch    = 1'b0;
        if (w_bypass) begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = 16'd0;
            w_out_nxt   = w_s_sync;
        end else begin
            unique case (r_state)
                ST_STABLE: begin
                    if (w_s_sync != r_out) begin
                        w_state_nxt = ST_QUALIFY;
                        w_cnt_nxt   = 16'd0;
                    end
                end
                ST_QUALIFY: begin
                    if (w_s_sync == r_out) begin
                        w_state_nxt = ST_STABLE;
                        w_glitch    = 1'b1;
                    end else if (iTick) begin
                        if (w_thresh) begin
                            w_out_nxt   = w_s_sync;
                            w_state_nxt = ST_STABLE;
                        end else begin
                            w_cnt_nxt = w_cnt_inc[15:0];
                        end
                    end
                end
                default: w_state_nxt = ST_STABLE;
            endcase
        end
    end

    // Saturating count of rejected pulses; clear has priority.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_glitch_cnt <= '0;
        end else if (iClear_glitch) begin
            r_glitch_cnt <= '0;
        end else if (w_glitch && !(&r_glitch_cnt)) begin
            r_glitch_cnt <= r_glitch_cnt + GLITCH_CNT_W'(1);
        end
    end

    assign output_sig        = r_out;
    assign output_busy       = (r_state == ST_QUALIFY);
    assign output_glitch_cnt = r_glitch_cnt;

endmodule

// File: doc/input_debounce_filter.md
Name: input_debounce_filter

Overview:
- Conditions one raw asynchronous board input (IOEXP interrupt, button, PG/ALERT line) before it reaches the edge-detector stage.
- Synchronizes the input into iClk and rejects pulses shorter than a programmable number of timebase ticks.
- Emits a clean level that the downstream edge detector consumes as its input_sig.
- Counts rejected glitches for debug/status readout.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops (legal range 2..4)
RST_VALUE, 1'b1, reset level of synchronizer chain and output_sig (1 suits active-low lines)
GLITCH_CNT_W, 8, width of the saturating glitch counter

Ports:
iClk  input  1  system clock
iRst_n  input  1  asynchronous active-low reset
iTick  input  1  single-cycle timebase enable pulse (e.g. 1 us / 1 ms strobe), synchronous to iClk
iEnable  input  1  1 = debounce active; 0 = bypass (output tracks synchronized input)
iDebounce_time  input  16  stable ticks required before output changes; 0 = bypass
iClear_glitch  input  1  synchronous clear of glitch counter
input_sig  input  1  raw asynchronous input
output_sig  output  1  debounced level
output_busy  output  1  high while a level change is being qualified
output_glitch_cnt  output  GLITCH_CNT_W  saturating count of rejected transitions

Behaviour:
Reset (iRst_n low, asynchronous):
- Sync chain and output_sig = RST_VALUE.
- State = STABLE; tick counter = 0; output_busy = 0; output_glitch_cnt = 0.

Synchronizer:
- input_sig passes through SYNC_STAGES flops; the last stage is s_sync.
- No other logic samples input_sig directly.

Bypass (iEnable = 0 or iDebounce_time = 0):
- output_sig <= s_sync every cycle. Latency from input_sig change = SYNC_STAGES + 1 clocks.
- State forced to STABLE, counter cleared, output_busy = 0, glitch counter holds.

FSM, two states:
- STABLE: if s_sync != output_sig, go to QUALIFY and clear the counter to 0. Otherwise stay.
- QUALIFY:
  - If s_sync == output_sig: glitch. Go to STABLE; output_glitch_cnt increments and saturates at all-ones.
  - Otherwise, on each cycle with iTick = 1, counter increments. When counter+1 >= iDebounce_time on a tick cycle, output_sig <= s_sync and the FSM returns to STABLE on the same edge.
- output_busy = 1 exactly while in QUALIFY.

Tick and counter rules:
- A tick on the same cycle as the STABLE->QUALIFY transition is not counted.
- Qualification therefore needs iDebounce_time full tick intervals of stable input.
- The 16-bit counter never overflows: commit occurs by value iDebounce_time <= 65535.
- Comparison uses the live iDebounce_time. If it is lowered mid-qualify below the current count, commit happens on the next tick.

Simultaneous events:
- Glitch return coinciding with the threshold tick: the glitch wins, output unchanged, glitch counted.
- iClear_glitch coinciding with a glitch increment: clear wins, counter = 0.
- iEnable falling mid-QUALIFY: bypass applies next edge, no glitch counted.

Other rules:
- Reset mid-qualify aborts immediately to reset values.
- The output only ever changes to the current s_sync value, so no spurious toggles.
- output_sig changes at most once per qualification.

Test Plan:
- Reset, RST_VALUE=1, input_sig=1: output_sig=1, output_busy=0, glitch_cnt=0. Drive input_sig=0 with iDebounce_time=5 and iTick every 10 clocks. Required: output_busy rises 3 clocks after the input change, output_sig falls on the 5th counted tick, output_busy falls on the same edge.
- Glitch: with iDebounce_time=5, drive input_sig low for 3 ticks, then back high. Required: output_sig stays 1, glitch_cnt=1, output_busy=0 after 3 clocks of sync latency. Repeat 300 times: glitch_cnt saturates at 255.
- Bypass: iDebounce_time=0, toggle input_sig every 4 clocks. Required: output_sig follows with exactly 3-clock latency, output_busy never asserts. Repeat with iEnable=0 and iDebounce_time=5: identical result.
- Boundary: input returns high on the very cycle of the 5th tick. Required: no output change, glitch_cnt +1. Separately, lower iDebounce_time from 10 to 2 after 4 ticks counted: output commits on the next tick.
- Async reset asserted mid-QUALIFY (counter=3): all outputs return to reset values immediately without a clock edge. After release, a stable low input qualifies from count 0.
- Clear priority: assert iClear_glitch on the same cycle a glitch is detected. Required: glitch_cnt=0 next cycle.
